// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial carry-lookahead adder.
// Contents: FSM state enum, nibble-count and index-width functions, default width.
// No ports; imported by cla_serial_add_seq and cla4_slice.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_NIB   = DEFAULT_WIDTH / 4;

   // Number of 4-bit passes needed for a width-bit operand.
   function automatic int nib_count(input int width);
      return width / 4;
   endfunction

   // Width of the nibble index counter; at least one bit even for a single pass.
   function automatic int idx_width(input int nib);
      return (nib <= 1) ? 1 : $clog2(nib);
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// Ports: a[3:0], b[3:0], cin in; sum[3:0], cout out.
// Zero latency; no flow control (combinational only).
module cla4_slice
   import cla_seq_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Every carry is flattened from p/g and cin so no carry ripples through the slice.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];

endmodule

// File: rtl/cla_serial_add_seq.sv
// WIDTH-bit adder built by time-sharing one cla4_slice, one nibble per clock.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_a/in_b/in_cin producer side;
//        out_valid/out_ready/out_sum/out_cout/out_ovf consumer side; busy status; in_sub
//        only when CLA_SEQ_SUB_EN is defined (1 = subtract A-B).
// Latency: accept edge T, result valid after edge T+NIB; accepts only in IDLE, holds result in DONE.
module cla_serial_add_seq
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef CLA_SEQ_SUB_EN
   input  logic             in_sub,
`endif
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int NIB = nib_count(WIDTH);
   localparam int IW  = idx_width(NIB);
   localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;     // effective B (already inverted for subtract)
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             sub_en;
   logic [IW+1:0]    bit_base;
   logic [3:0]       s_a;
   logic [3:0]       s_b;
   logic [3:0]       s_sum;
   logic             s_cout;

`ifdef CLA_SEQ_SUB_EN
   assign sub_en = in_sub;
`else
   assign sub_en = 1'b0;
`endif

   // Nibble idx starts at bit idx*4.
   assign bit_base = {idx_q, 2'b00};
   assign s_a      = a_q[bit_base +: 4];
   assign s_b      = b_q[bit_base +: 4];

   cla4_slice u_slice (
      .a    (s_a),
      .b    (s_b),
      .cin  (carry_q),
      .sum  (s_sum),
      .cout (s_cout)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               // Subtract is A + ~B + 1: invert B once here and seed the carry.
               b_d     = in_b ^ {WIDTH{sub_en}};
               carry_d = sub_en ? 1'b1 : in_cin;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[bit_base +: 4] = s_sum;
            carry_d              = s_cout;
            idx_d                = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               cout_d  = s_cout;
               // Final sum MSB is bit 3 of the last slice output.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_sum[3] != a_q[WIDTH-1]);
               idx_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_cla_serial_add_seq.sv
// Directed testbench for cla_serial_add_seq (WIDTH=16, NIB=4).
// Exercises reset, add/carry/overflow, DONE hold, mid-run reset, back-to-back ops,
// and subtract when CLA_SEQ_SUB_EN is defined.
module tb_cla_serial_add_seq;

   localparam int WIDTH = 16;
   localparam int NIB   = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;
   logic             busy;
`ifdef CLA_SEQ_SUB_EN
   logic             in_sub;
`endif

   int vectors;
   int miscompares;

   cla_serial_add_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
`ifdef CLA_SEQ_SUB_EN
      .in_sub    (in_sub),
`endif
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands in IDLE and clock the accept edge; in_valid drops afterwards.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub);
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
`ifdef CLA_SEQ_SUB_EN
      in_sub   = sub;
`else
      if (sub) in_cin = cin;
`endif
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid, bounded at 20.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if ({in_ready, out_valid, busy, out_cout, out_ovf} !== 5'b10000 || out_sum !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset: rdy/vld/busy/cout/ovf=%b sum=%h, need 10000 sum=0000",
                  {in_ready, out_valid, busy, out_cout, out_ovf}, out_sum);
      end
   endtask

   task automatic test_basic_latency();
      int cyc;
      start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL run_status: rdy=%b busy=%b vld=%b, need 0 1 0", in_ready, busy, out_valid);
      end
      // Accept cycle plus NIB run cycles: valid shows NIB edges after the accept edge.
      wait_valid(cyc);
      vectors++;
      if (cyc != NIB) begin
         miscompares++;
         $display("FAIL latency: out_valid after %0d edges, need %0d", cyc, NIB);
      end
      vectors++;
      if (out_sum !== 16'h0100 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL add_00ff: sum=%h cout=%b ovf=%b, need 0100 0 0", out_sum, out_cout, out_ovf);
      end
      handshake();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL release: vld=%b rdy=%b, need 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_carry_ovf();
      int cyc;
      start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_valid(cyc);
      vectors++;
      if (cyc != NIB || out_sum !== 16'h0000 || out_cout !== 1'b1 || out_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL add_ffff: cyc=%0d sum=%h cout=%b ovf=%b, need %0d 0000 1 0",
                  cyc, out_sum, out_cout, out_ovf, NIB);
      end
      handshake();
      start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait_valid(cyc);
      vectors++;
      if (cyc != NIB || out_sum !== 16'h8000 || out_cout !== 1'b0 || out_ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL add_7fff: cyc=%0d sum=%h cout=%b ovf=%b, need %0d 8000 0 1",
                  cyc, out_sum, out_cout, out_ovf, NIB);
      end
      handshake();
   endtask

   task automatic test_hold_done();
      int cyc;
      start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
      wait_valid(cyc);
      // A new operand waits on the input while the result is held.
      in_a     = 16'hAAAA;
      in_b     = 16'h1111;
      in_cin   = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h5556 ||
             out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_%0d: vld=%b rdy=%b sum=%h cout=%b ovf=%b, need 1 0 5556 0 0",
                     i, out_valid, in_ready, out_sum, out_cout, out_ovf);
         end
         tick();
      end
      in_valid = 1'b0;
      handshake();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 16'h5556) begin
         miscompares++;
         $display("FAIL hold_release: vld=%b busy=%b sum=%h, need 0 0 5556", out_valid, busy, out_sum);
      end
   endtask

   task automatic test_mid_reset();
      int cyc;
      bit seen;
      start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
      tick();                       // first RUN edge; now in the second RUN cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0000) begin
         miscompares++;
         $display("FAIL mid_reset: rdy=%b busy=%b vld=%b sum=%h, need 1 0 0 0000",
                  in_ready, busy, out_valid, out_sum);
      end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_no_valid: out_valid rose=%b, need 0", seen);
      end
      start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_valid(cyc);
      vectors++;
      if (cyc != NIB || out_sum !== 16'h0002 || out_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_add: cyc=%0d sum=%h cout=%b, need %0d 0002 0",
                  cyc, out_sum, out_cout, NIB);
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      int cyc;
      in_a     = 16'h1111;
      in_b     = 16'h2222;
      in_cin   = 1'b0;
      in_valid = 1'b1;
      tick();                       // op1 accepted
      in_a = 16'h0F0F;              // op2 presented immediately and held
      in_b = 16'h00F1;
      wait_valid(cyc);
      vectors++;
      if (cyc != NIB || out_sum !== 16'h3333 || out_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_op1: cyc=%0d sum=%h cout=%b, need %0d 3333 0", cyc, out_sum, out_cout, NIB);
      end
      out_ready = 1'b1;
      tick();                       // DONE handshake edge; op2 not yet taken
      out_ready = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_gap: rdy=%b busy=%b, need 1 0", in_ready, busy);
      end
      tick();                       // op2 accepted
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_accept2: rdy=%b busy=%b, need 0 1", in_ready, busy);
      end
      wait_valid(cyc);
      vectors++;
      if (cyc != NIB || out_sum !== 16'h1000 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_op2: cyc=%0d sum=%h cout=%b ovf=%b, need %0d 1000 0 0",
                  cyc, out_sum, out_cout, out_ovf, NIB);
      end
      handshake();
   endtask

`ifdef CLA_SEQ_SUB_EN
   task automatic test_subtract();
      int cyc;
      start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_valid(cyc);
      vectors++;
      if (out_sum !== 16'hFFFE || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL sub_5_7: sum=%h cout=%b ovf=%b, need fffe 0 0", out_sum, out_cout, out_ovf);
      end
      handshake();
      start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_valid(cyc);
      vectors++;
      if (out_sum !== 16'h7FFF || out_cout !== 1'b1 || out_ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL sub_8000_1: sum=%h cout=%b ovf=%b, need 7fff 1 1", out_sum, out_cout, out_ovf);
      end
      handshake();
      start_op(16'h0003, 16'h0004, 1'b1, 1'b0);
      wait_valid(cyc);
      vectors++;
      if (out_sum !== 16'h0008 || out_cout !== 1'b0) begin
         miscompares++;
         $display("FAIL sub0_add: sum=%h cout=%b, need 0008 0", out_sum, out_cout);
      end
      handshake();
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_a        = '0;
      in_b        = '0;
      in_cin      = 1'b0;
      out_ready   = 1'b0;
`ifdef CLA_SEQ_SUB_EN
      in_sub      = 1'b0;
`endif
      test_reset();
      test_basic_latency();
      test_carry_ovf();
      test_hold_done();
      test_mid_reset();
      test_back_to_back();
`ifdef CLA_SEQ_SUB_EN
      test_subtract();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
